iic_target: RTL and testbench

Synthesizable IIC target (slave) that answers the DVI encoder configuration master. It models the encoder's register file at device address 0x76. The bench and the loopback build instantiate it on the same IIC_SDA_VIDEO/IIC_SCL_VIDEO nets that the encoder-init master drives. Every register write is exposed as a strobe, so init sequences can be checked cycle-exactly. A side read port lets logic inspect the register file.

---
 rtl/iic_target.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_iic_target.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_target.sv
// IIC target modelling the DVI encoder register file: write strobes, side read port.
// Build option: define IIC_TARGET_READ_EN to ACK and serve R/W=1 transfers (RDATA/MACK states).
module iic_target #(
    parameter logic [6:0] DEV_ADDR = 7'h76,
    parameter int         REG_AW   = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              scl,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              wr_valid,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam int NREG = 32'd1 << REG_AW;
    localparam logic [REG_AW-1:0] PTR_ONE  = {{(REG_AW-1){1'b0}}, 1'b1};
    localparam logic [REG_AW-1:0] PTR_ZERO = {REG_AW{1'b0}};

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ADDR   = 4'd1,
        ST_ACK_A  = 4'd2,
        ST_SUB    = 4'd3,
        ST_ACK_S  = 4'd4,
        ST_WDATA  = 4'd5,
        ST_ACK_W  = 4'd6,
        ST_RDATA  = 4'd7,
        ST_MACK   = 4'd8,
        ST_IGNORE = 4'd9
    } state_t;

    logic scl_meta_r, scl_sync_r, scl_dly_r;
    logic sda_meta_r, sda_sync_r, sda_dly_r;
    logic scl_rise_s, scl_fall_s, start_s, stop_s, byte_done_s;

    state_t            state_r, state_s, addr_next_s, ack_exit_s;
    logic [2:0]        bit_cnt_r, bit_cnt_s;
    logic [6:0]        shift_r, shift_s;
    logic [7:0]        byte_s;
    logic [REG_AW-1:0] ptr_r, ptr_s;
    logic              sda_oe_r, sda_oe_s;
    logic              busy_r, busy_s;
    logic              wr_valid_r, wr_valid_s;
    logic [REG_AW-1:0] wr_addr_r, wr_addr_s;
    logic [7:0]        wr_data_r, wr_data_s;
    logic              reg_we_s;
    logic [7:0]        regs_r [NREG];
    logic [7:0]        dbg_data_r;
`ifdef IIC_TARGET_READ_EN
    logic              rw_r, rw_s;
    logic [6:0]        tx_r, tx_s;
    logic [7:0]        rd_byte_s;
`endif

    // Two-flop synchronizers plus one delay stage; reset to the idle bus level.
    always_ff @(posedge clock) begin
        if (reset) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_dly_r  <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_dly_r  <= 1'b1;
        end else begin
            scl_meta_r <= scl;
            scl_sync_r <= scl_meta_r;
            scl_dly_r  <= scl_sync_r;
            sda_meta_r <= sda_i;
            sda_sync_r <= sda_meta_r;
            sda_dly_r  <= sda_sync_r;
        end
    end

    assign scl_rise_s  = scl_sync_r & ~scl_dly_r;
    assign scl_fall_s  = ~scl_sync_r & scl_dly_r;
    assign start_s     = scl_sync_r & scl_dly_r & sda_dly_r & ~sda_sync_r;
    assign stop_s      = scl_sync_r & scl_dly_r & ~sda_dly_r & sda_sync_r;
    assign byte_s      = {shift_r, sda_sync_r};
    assign byte_done_s = scl_rise_s & (bit_cnt_r == 3'd7);
`ifdef IIC_TARGET_READ_EN
    assign rd_byte_s   = regs_r[ptr_r];
`endif

    // Next-state and datapath logic; bus conditions override bit processing.
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        ptr_s       = ptr_r;
        sda_oe_s    = sda_oe_r;
        busy_s      = busy_r;
        wr_valid_s  = 1'b0;
        wr_addr_s   = wr_addr_r;
        wr_data_s   = wr_data_r;
        reg_we_s    = 1'b0;
        addr_next_s = ST_IGNORE;
        ack_exit_s  = ST_WDATA;
`ifdef IIC_TARGET_READ_EN
        rw_s        = rw_r;
        tx_s        = tx_r;
`endif

        if (byte_s[7:1] == DEV_ADDR) begin
`ifdef IIC_TARGET_READ_EN
            addr_next_s = ST_ACK_A;
`else
            // Reads are not served in this build, so they are left un-ACKed.
            if (byte_s[0] == 1'b0) begin
                addr_next_s = ST_ACK_A;
            end else begin
                addr_next_s = ST_IGNORE;
            end
`endif
        end else begin
            addr_next_s = ST_IGNORE;
        end

        if (state_r == ST_ACK_A) begin
`ifdef IIC_TARGET_READ_EN
            if (rw_r) begin
                ack_exit_s = ST_RDATA;
            end else begin
                ack_exit_s = ST_SUB;
            end
`else
            ack_exit_s = ST_SUB;
`endif
        end else begin
            ack_exit_s = ST_WDATA;
        end

        if (stop_s) begin
            state_s   = ST_IDLE;
            bit_cnt_s = 3'd0;
            sda_oe_s  = 1'b0;
            busy_s    = 1'b0;
        end else if (start_s) begin
            state_s   = ST_ADDR;
            bit_cnt_s = 3'd0;
            sda_oe_s  = 1'b0;
            busy_s    = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_ADDR, ST_SUB, ST_WDATA: begin
                    if (scl_rise_s) begin
                        shift_s   = byte_s[6:0];
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end else begin
                        shift_s   = shift_r;
                    end
                    if (byte_done_s) begin
                        case (state_r)
                            ST_ADDR: begin
                                state_s = addr_next_s;
`ifdef IIC_TARGET_READ_EN
                                rw_s    = byte_s[0];
`endif
                            end
                            ST_SUB: begin
                                ptr_s   = byte_s[REG_AW-1:0];
                                state_s = ST_ACK_S;
                            end
                            ST_WDATA: begin
                                reg_we_s   = 1'b1;
                                wr_valid_s = 1'b1;
                                wr_addr_s  = ptr_r;
                                wr_data_s  = byte_s;
                                ptr_s      = ptr_r + PTR_ONE;
                                state_s    = ST_ACK_W;
                            end
                            default: begin
                                state_s = ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_ACK_A, ST_ACK_S, ST_ACK_W: begin
                    // sda_oe doubles as the phase flag: first fall drives, second fall exits.
                    if (scl_fall_s && sda_oe_r) begin
                        state_s  = ack_exit_s;
                        sda_oe_s = 1'b0;
`ifdef IIC_TARGET_READ_EN
                        if (ack_exit_s == ST_RDATA) begin
                            tx_s     = rd_byte_s[6:0];
                            sda_oe_s = ~rd_byte_s[7];
                        end else begin
                            tx_s     = tx_r;
                        end
`endif
                    end else if (scl_fall_s) begin
                        sda_oe_s = 1'b1;
                    end else begin
                        sda_oe_s = sda_oe_r;
                    end
                end
`ifdef IIC_TARGET_READ_EN
                ST_RDATA: begin
                    if (scl_rise_s) begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            ptr_s   = ptr_r + PTR_ONE;
                            state_s = ST_MACK;
                        end else begin
                            state_s = ST_RDATA;
                        end
                    end else if (scl_fall_s) begin
                        sda_oe_s = ~tx_r[6];
                        tx_s     = {tx_r[5:0], 1'b0};
                    end else begin
                        sda_oe_s = sda_oe_r;
                    end
                end
                ST_MACK: begin
                    // bit_cnt==1 marks that the master's ACK has been sampled.
                    if (scl_fall_s) begin
                        if (bit_cnt_r == 3'd1) begin
                            tx_s      = rd_byte_s[6:0];
                            sda_oe_s  = ~rd_byte_s[7];
                            bit_cnt_s = 3'd0;
                            state_s   = ST_RDATA;
                        end else begin
                            sda_oe_s  = 1'b0;
                        end
                    end else if (scl_rise_s) begin
                        if (sda_sync_r) begin
                            state_s   = ST_IGNORE;
                        end else begin
                            bit_cnt_s = 3'd1;
                        end
                    end else begin
                        state_s = ST_MACK;
                    end
                end
`endif
                ST_IGNORE: begin
                    sda_oe_s = 1'b0;
                end
                default: begin
                    state_s  = ST_IDLE;
                    sda_oe_s = 1'b0;
                end
            endcase
        end
    end

    // FSM and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 7'd0;
            ptr_r      <= PTR_ZERO;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            wr_valid_r <= 1'b0;
            wr_addr_r  <= PTR_ZERO;
            wr_data_r  <= 8'h00;
`ifdef IIC_TARGET_READ_EN
            rw_r       <= 1'b0;
            tx_r       <= 7'd0;
`endif
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            ptr_r      <= ptr_s;
            sda_oe_r   <= sda_oe_s;
            busy_r     <= busy_s;
            wr_valid_r <= wr_valid_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
`ifdef IIC_TARGET_READ_EN
            rw_r       <= rw_s;
            tx_r       <= tx_s;
`endif
        end
    end

    // Register file and registered side read port (old data on same-cycle write).
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= 8'h00;
            end
            dbg_data_r <= 8'h00;
        end else begin
            if (reg_we_s) begin
                regs_r[ptr_r] <= wr_data_s;
            end
            dbg_data_r <= regs_r[dbg_addr];
        end
    end

    assign sda_oe   = sda_oe_r;
    assign wr_valid = wr_valid_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign busy     = busy_r;
    assign dbg_data = dbg_data_r;

endmodule

// File: tb/tb_iic_target.sv
// Directed bench for iic_target: a bit-banged bus master plus table-driven write vectors.
module tb_iic_target;

    logic       clock = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_sda;
    logic       sda_i;
    logic       sda_oe;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_data;

    int          checks = 0;
    int          errors = 0;
    int          h = 6;
    logic        oe_seen;
    logic [14:0] wrq [$];

    assign sda_i = m_sda & ~sda_oe;

    always #20 clock = ~clock;

    iic_target dut (
        .clock    (clock),
        .reset    (reset),
        .scl      (scl),
        .sda_i    (sda_i),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Capture every committed write and whether the target ever pulled SDA.
    always @(negedge clock) begin
        if (wr_valid) wrq.push_back({wr_addr, wr_data});
        if (sda_oe) oe_seen = 1'b1;
    end

    typedef struct {
        logic [7:0] dev;
        logic [7:0] sub;
        logic [7:0] d0;
        logic [7:0] d1;
        int         ndata;
        int         half;
        logic       ack;
        int         exp_n;
        logic [6:0] a0;
        logic [7:0] e0;
        logic [6:0] a1;
        logic [7:0] e1;
    } wr_vec_t;

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
    } dbg_vec_t;

    wr_vec_t  wv [5];
    dbg_vec_t dv [7];

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        scl = 1'b0; cyc(2);
        m_sda = b;  cyc(h - 2);
        scl = 1'b1; cyc(h);
    endtask

    task automatic start_cond();
        m_sda = 1'b0; cyc(h);
    endtask

    task automatic rstart_cond();
        send_bit(1'b1);
        m_sda = 1'b0; cyc(h);
    endtask

    task automatic stop_cond();
        scl = 1'b0;   cyc(2);
        m_sda = 1'b0; cyc(h - 2);
        scl = 1'b1;   cyc(h);
        m_sda = 1'b1; cyc(2);
        chk("busy_before_stop", busy, 1);
        cyc(1);
        chk("busy_after_stop", busy, 0);
        cyc(h);
    endtask

    task automatic master_byte(input logic [7:0] b, input logic exp_ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        scl = 1'b0;   cyc(1);
        m_sda = 1'b1; cyc(1);
        chk("ack_oe_early", sda_oe, 0);
        cyc(1);
        chk("ack_oe_edge", sda_oe, exp_ack);
        cyc(h - 3);
        scl = 1'b1;   cyc(h / 2);
        chk("ack_bus", !sda_i, exp_ack);
        cyc(h - h / 2);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            scl = 1'b0;   cyc(1);
            m_sda = 1'b1; cyc(h - 1);
            scl = 1'b1;   cyc(h / 2);
            d = {d[6:0], sda_i};
            cyc(h - h / 2);
        end
        scl = 1'b0;   cyc(2);
        m_sda = nack; cyc(h - 2);
        scl = 1'b1;   cyc(h);
    endtask

    initial begin
        logic [7:0] rd;

        wv[0] = '{8'hEC, 8'h49, 8'hC0, 8'h09, 2, 125, 1'b1, 2, 7'h49, 8'hC0, 7'h4A, 8'h09};
        wv[1] = '{8'hEC, 8'h49, 8'hC0, 8'h09, 2, 6,   1'b1, 2, 7'h49, 8'hC0, 7'h4A, 8'h09};
        wv[2] = '{8'hA0, 8'h21, 8'h00, 8'h00, 0, 6,   1'b0, 0, 7'h00, 8'h00, 7'h00, 8'h00};
        wv[3] = '{8'hEC, 8'h7F, 8'h11, 8'h22, 2, 6,   1'b1, 2, 7'h7F, 8'h11, 7'h00, 8'h22};
        wv[4] = '{8'hEC, 8'h21, 8'h5A, 8'hA5, 2, 6,   1'b1, 2, 7'h21, 8'h5A, 7'h22, 8'hA5};
        dv[0] = '{7'h4A, 8'h09};
        dv[1] = '{7'h49, 8'hC0};
        dv[2] = '{7'h7F, 8'h11};
        dv[3] = '{7'h00, 8'h22};
        dv[4] = '{7'h21, 8'h5A};
        dv[5] = '{7'h22, 8'hA5};
        dv[6] = '{7'h4B, 8'h00};

        reset = 1'b1; scl = 1'b1; m_sda = 1'b1; dbg_addr = 7'h00; oe_seen = 1'b0;
        cyc(4);
        reset = 1'b0;
        cyc(1);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dbg_data", dbg_data, 0);

        for (int v = 0; v < 5; v++) begin
            h = wv[v].half;
            wrq.delete();
            cyc(4);
            oe_seen = 1'b0;
            start_cond();
            master_byte(wv[v].dev, wv[v].ack);
            master_byte(wv[v].sub, wv[v].ack);
            if (wv[v].ndata > 0) master_byte(wv[v].d0, wv[v].ack);
            if (wv[v].ndata > 1) master_byte(wv[v].d1, wv[v].ack);
            stop_cond();
            chk("wr_count", wrq.size(), wv[v].exp_n);
            chk("oe_seen", oe_seen, wv[v].ack);
            if (wv[v].exp_n > 0 && wrq.size() > 0) chk("wr_first", wrq[0], {wv[v].a0, wv[v].e0});
            if (wv[v].exp_n > 1 && wrq.size() > 1) chk("wr_second", wrq[1], {wv[v].a1, wv[v].e1});
        end

        for (int i = 0; i < 7; i++) begin
            dbg_addr = dv[i].a;
            cyc(1);
            chk("dbg_read", dbg_data, dv[i].d);
        end

        h = 6;
        wrq.delete();
        oe_seen = 1'b0;
        start_cond();
`ifdef IIC_TARGET_READ_EN
        master_byte(8'hEC, 1'b1);
        master_byte(8'h21, 1'b1);
        rstart_cond();
        master_byte(8'hED, 1'b1);
        read_byte(rd, 1'b0);
        chk("read_byte0", rd, 8'h5A);
        read_byte(rd, 1'b1);
        chk("read_byte1", rd, 8'hA5);
        stop_cond();
        chk("read_no_wr", wrq.size(), 0);
`else
        master_byte(8'hED, 1'b0);
        stop_cond();
        chk("read_nack_no_wr", wrq.size(), 0);
        chk("read_nack_oe", oe_seen, 0);
`endif

        // Abort: STOP mid data byte, then reset mid address byte.
        wrq.delete();
        cyc(4);
        start_cond();
        master_byte(8'hEC, 1'b1);
        master_byte(8'h30, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        stop_cond();
        chk("abort_no_wr", wrq.size(), 0);
        start_cond();
        chk("abort_busy", busy, 1);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        reset = 1'b1; scl = 1'b1; m_sda = 1'b1; dbg_addr = 7'h30;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("abort_sda_oe", sda_oe, 0);
        chk("abort_wr_valid", wr_valid, 0);
        chk("abort_wr_addr", wr_addr, 0);
        chk("abort_wr_data", wr_data, 0);
        chk("abort_busy_rst", busy, 0);
        chk("abort_dbg", dbg_data, 0);
        for (int i = 0; i < 128; i++) begin
            dbg_addr = 7'(i);
            cyc(1);
            chk("cleared_reg", dbg_data, 0);
        end
        chk("abort_wr_total", wrq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
